// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM plus I/O page with cycle counter and a store-fed output FIFO.
// Loads are combinational; stores, counter and FIFO update at the rising edge; out_valid/out_data come from registers.
module data_mem_responder #(
  parameter int MEM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] SEL_CYCLE  = 2'd0;
  localparam logic [1:0] SEL_TXDATA = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;

  logic [31:0]   ram [MEM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [31:0]   cycle_cnt;

  logic          io_sel;
  logic [1:0]    reg_sel;
  logic [AW-1:0] word_idx;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          push_ok;
  logic          cycle_wr;
  logic          ovf_clr;
  logic [31:0]   status;
  logic          unused_addr;

  assign io_sel   = address_to_mem[31];
  assign reg_sel  = address_to_mem[3:2];
  assign word_idx = address_to_mem[AW+1:2];
  // Most address bits are deliberately ignored (RAM aliasing, sparse I/O decode).
  assign unused_addr = ^address_to_mem;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop      = out_valid && out_ready;
  assign push     = WE && io_sel && (reg_sel == SEL_TXDATA);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign cycle_wr = WE && io_sel && (reg_sel == SEL_CYCLE);
  assign ovf_clr  = WE && io_sel && (reg_sel == SEL_STATUS) && data_to_mem[8];

  assign status    = {23'd0, overflow, 6'(count), full, empty};
  assign out_valid = !empty;
  assign out_data  = fifo_mem[rd_ptr];

  always_comb begin
    data_from_mem = '0;
    if (!io_sel) begin
      data_from_mem = ram[word_idx];
    end else begin
      case (reg_sel)
        SEL_CYCLE:  data_from_mem = cycle_cnt;
        SEL_STATUS: data_from_mem = status;
        default:    data_from_mem = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; reset only blocks writes in its cycle.
  always_ff @(posedge clk) begin
    if (!reset && WE && !io_sel) ram[word_idx] <= data_to_mem;
    if (!reset && push_ok)       fifo_mem[wr_ptr] <= data_to_mem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_wr ? data_to_mem : cycle_cnt + 32'd1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus a randomized run against a queue/array model.
module tb_data_mem_responder;
  localparam int MW = 256;
  localparam int FD = 4;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;

  // reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_q [$];
  logic [31:0] m_cnt;
  bit          m_ovf;

  data_mem_responder #(.MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .WE(WE), .address_to_mem(address_to_mem),
    .data_to_mem(data_to_mem), .data_from_mem(data_from_mem),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit 32 set means the expected value is defined
  function automatic logic [32:0] model_read(input logic [31:0] a);
    int idx;
    logic [31:0] st;
    if (a[31] == 1'b0) begin
      idx = int'((a & 32'h7FFF_FFFF) / 4) % MW;
      if (m_ram.exists(idx)) return {1'b1, m_ram[idx]};
      return 33'd0;
    end
    case ((a / 4) % 4)
      0: return {1'b1, m_cnt};
      2: begin
        st = 32'(m_q.size()) * 4 + (m_ovf ? 32'h100 : 32'h0);
        if (m_q.size() == FD) st = st + 2;
        if (m_q.size() == 0) st = st + 1;
        return {1'b1, st};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic tick();
    bit pop;
    bit push;
    bit acc;
    int sel;
    sel  = int'((address_to_mem / 4) % 4);
    pop  = (m_q.size() > 0) && out_ready;
    push = WE && address_to_mem[31] && (sel == 1);
    acc  = (m_q.size() < FD) || pop;
    if (reset) begin
      m_cnt = 0;
      m_q.delete();
      m_ovf = 0;
    end else begin
      if (WE && !address_to_mem[31])
        m_ram[int'((address_to_mem & 32'h7FFF_FFFF) / 4) % MW] = data_to_mem;
      m_cnt = (WE && address_to_mem[31] && sel == 0) ? data_to_mem : m_cnt + 1;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (acc) m_q.push_back(data_to_mem);
        else m_ovf = 1;
      end
      if (WE && address_to_mem[31] && sel == 2 && data_to_mem[8]) m_ovf = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    WE = we;
    address_to_mem = a;
    data_to_mem = d;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h8000_0000, 32'h0);
      exp = 32'(i);
      checks++;
      if (data_from_mem !== exp) begin
        failures++;
        $display("FAIL cycle_after_reset[%0d] got=%h exp=%h", i, data_from_mem, exp);
      end
      tick();
    end
    drive(1'b0, 32'h8000_0008, 32'h0);
    checks++;
    if (data_from_mem !== 32'h1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got=%h valid=%b exp=00000001 valid=0", data_from_mem, out_valid);
    end
    tick();
  endtask

  task automatic test_counter();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFFE;
    exp[1] = 32'hFFFF_FFFF;
    exp[2] = 32'h0;
    drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFE);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h8000_0000, 32'h0);
      checks++;
      if (data_from_mem !== exp[i]) begin
        failures++;
        $display("FAIL cycle_wrap[%0d] got=%h exp=%h", i, data_from_mem, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_ram();
    drive(1'b1, 32'h0000_0010, 32'h1234_5678);
    tick();
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    checks++;
    if (data_from_mem !== 32'h1234_5678) begin
      failures++;
      $display("FAIL ram_same_cycle got=%h exp=12345678", data_from_mem);
    end
    tick();
    drive(1'b0, 32'h0000_0010, 32'h0);
    checks++;
    if (data_from_mem !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ram_readback got=%h exp=deadbeef", data_from_mem);
    end
    tick();
    drive(1'b0, 32'h0000_0010 + 4 * MW, 32'h0);
    checks++;
    if (data_from_mem !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ram_alias got=%h exp=deadbeef", data_from_mem);
    end
    tick();
  endtask

  task automatic drain_expect(input string name, input logic [31:0] words [$]);
    out_ready = 1'b1;
    foreach (words[i]) begin
      drive(1'b0, 32'h0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== words[i]) begin
        failures++;
        $display("FAIL %s[%0d] got valid=%b data=%h exp valid=1 data=%h", name, i, out_valid, out_data, words[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    drive(1'b0, 32'h8000_0008, 32'h0);
    checks++;
    if (out_valid !== 1'b0 || data_from_mem !== 32'h1) begin
      failures++;
      $display("FAIL %s_empty got valid=%b status=%h exp valid=0 status=00000001", name, out_valid, data_from_mem);
    end
    tick();
  endtask

  task automatic test_fifo_order();
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0004, 32'h11); tick();
    drive(1'b1, 32'h8000_0004, 32'h22); tick();
    drive(1'b1, 32'h8000_0004, 32'h33); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h8000_0008, 32'h0);
      checks++;
      if (data_from_mem !== 32'h0C || out_valid !== 1'b1 || out_data !== 32'h11) begin
        failures++;
        $display("FAIL fifo_hold[%0d] got status=%h valid=%b data=%h exp 0000000c 1 00000011", i, data_from_mem, out_valid, out_data);
      end
      tick();
    end
    drain_expect("fifo_order", '{32'h11, 32'h22, 32'h33});
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h8000_0004, 32'hA0 + 32'(i));
      tick();
    end
    drive(1'b0, 32'h8000_0008, 32'h0);
    checks++;
    if (data_from_mem !== 32'h112) begin
      failures++;
      $display("FAIL ovf_status got=%h exp=00000112", data_from_mem);
    end
    tick();
    drive(1'b1, 32'h8000_0008, 32'h100);
    tick();
    drive(1'b0, 32'h8000_0008, 32'h0);
    checks++;
    if (data_from_mem !== 32'h12) begin
      failures++;
      $display("FAIL ovf_clear got=%h exp=00000012", data_from_mem);
    end
    tick();
    drain_expect("ovf_drain", '{32'hA0, 32'hA1, 32'hA2, 32'hA3});
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8000_0004, 32'hB0 + 32'(i));
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0004, 32'h55);
    tick();
    out_ready = 1'b0;
    drive(1'b0, 32'h8000_0008, 32'h0);
    checks++;
    if (data_from_mem !== 32'h12) begin
      failures++;
      $display("FAIL full_pushpop_status got=%h exp=00000012", data_from_mem);
    end
    tick();
    drain_expect("full_pushpop", '{32'hB1, 32'hB2, 32'hB3, 32'h55});
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0004, 32'hC0 + 32'(i));
      tick();
    end
    drive(1'b1, 32'h8000_0000, 32'd100);
    tick();
    reset = 1'b1;
    drive(1'b1, 32'h8000_0004, 32'hEE);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h8000_0000, 32'h0);
    checks++;
    if (data_from_mem !== 32'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_cycle got=%h valid=%b exp=00000000 valid=0", data_from_mem, out_valid);
    end
    tick();
    drive(1'b0, 32'h8000_0008, 32'h0);
    checks++;
    if (data_from_mem !== 32'h1) begin
      failures++;
      $display("FAIL rst_mid_status got=%h exp=00000001", data_from_mem);
    end
    tick();
    drive(1'b0, 32'h0000_0010, 32'h0);
    checks++;
    if (data_from_mem !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rst_mid_ram got=%h exp=deadbeef", data_from_mem);
    end
    tick();
  endtask

  task automatic test_random();
    logic [32:0] exp;
    logic [31:0] r;
    int op;
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 11);
      r = $urandom();
      case (op)
        0, 1:    drive(1'b1, r & 32'h7FFF_FC3F, $urandom());
        2, 3:    drive(1'b0, r & 32'h7FFF_FC3F, 32'h0);
        4, 5, 6: drive(1'b1, (r & 32'h7FFF_FFF3) | 32'h8000_0004, $urandom());
        7:       drive(1'b0, (r & 32'h7FFF_FFF3) | 32'h8000_0008, 32'h0);
        8:       drive(1'b0, (r & 32'h7FFF_FFF3) | 32'h8000_0000, 32'h0);
        9:       drive(1'b1, (r & 32'h7FFF_FFF3) | 32'h8000_0008, $urandom());
        10:      drive(1'b0, r | 32'h8000_0000, 32'h0);
        default: drive(1'b1, (r & 32'h7FFF_FFF3) | 32'h8000_0000 | (32'($urandom_range(0, 1)) << 3) | 32'hC, $urandom());
      endcase
      exp = model_read(address_to_mem);
      if (exp[32]) begin
        checks++;
        if (data_from_mem !== exp[31:0]) begin
          failures++;
          $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", n, address_to_mem, data_from_mem, exp[31:0]);
        end
      end
      checks++;
      if (out_valid !== (m_q.size() > 0)) begin
        failures++;
        $display("FAIL rand_valid[%0d] got=%b exp=%b", n, out_valid, m_q.size() > 0);
      end else if (m_q.size() > 0) begin
        checks++;
        if (out_data !== m_q[0]) begin
          failures++;
          $display("FAIL rand_head[%0d] got=%h exp=%h", n, out_data, m_q[0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_cnt = 0;
    m_ovf = 0;
    reset = 1'b1;
    WE = 1'b0;
    address_to_mem = 32'h0;
    data_to_mem = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_counter();
    test_ram();
    test_fifo_order();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the single-cycle processor's data port. It serves loads and stores issued on WE/address_to_mem/data_to_mem and returns load data on data_from_mem in the same cycle. It decodes the address into a word RAM and a small memory-mapped I/O region. The I/O region holds a free-running cycle counter and an output FIFO that drains store data to a valid/ready debug port.

## Interface
Parameters:
- MEM_WORDS, 256: RAM depth in 32-bit words; power of two, at least 2.
- FIFO_DEPTH, 4: output FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- WE  input  1  store strobe from the processor; 1 means write this cycle.
- address_to_mem  input  32  byte address from the processor; bits [1:0] are ignored.
- data_to_mem  input  32  store data.
- data_from_mem  output  32  load data; combinational from address and current state.
- out_data  output  32  FIFO head word.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  sink accepts the head word this cycle.

## Operation
- Address decode:
  - address_to_mem[31]=0 selects the RAM. The word index is address_to_mem[log2(MEM_WORDS)+1:2]. Higher bits are ignored, so the RAM aliases (wraps) across the low half of the address space.
  - address_to_mem[31]=1 selects I/O. Only bits [3:2] are decoded; all other bits are ignored.
- I/O registers, selected by bits [3:2]:
  - 0, CYCLE:
    - Read returns the 32-bit counter.
    - Write loads data_to_mem into the counter.
  - 1, TXDATA:
    - Write pushes data_to_mem into the FIFO.
    - Read returns 0.
  - 2, STATUS, read:
    - bit0 = empty.
    - bit1 = full.
    - bits [7:2] = occupancy count, zero-extended.
    - bit8 = sticky overflow.
    - All other bits are 0.
  - 2, STATUS, write: writing with data_to_mem[8]=1 clears overflow; all other bits are ignored.
  - 3: reads return 0; writes have no effect.
- RAM:
  - Full-word writes only; there are no byte enables.
  - The write commits at the clock edge when WE=1.
  - Contents are not cleared by reset and are X until first written.
- Cycle counter:
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A CYCLE write overrides the increment in that cycle.
- FIFO:
  - pop = out_valid && out_ready.
  - push = WE && TXDATA selected.
  - A push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow is set to 1.
  - Push and pop in the same cycle leave count unchanged.
  - Data leaves in strict push order.
  - out_data is the head entry when out_valid=1. It is don't-care when empty.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Simultaneous overflow set and STATUS clear in the same cycle cannot occur, since only one store is issued per cycle.
- When WE=0, all writes, pushes, counter loads and overflow clears are suppressed.

## Timing
- Reads are combinational with zero latency.
  - A read in the same cycle as a write to that location returns the old value.
  - The new value is visible from the next cycle.
- Stores take effect at the rising edge ending the cycle in which WE=1.
- After a FIFO push, out_valid rises in the next cycle. The push-to-out_valid latency is 1 cycle.
- out_valid and out_data are register-driven: no combinational path from WE/address/data or from out_ready.
- out_data must stay stable while out_valid=1 and out_ready=0.
- Reset, sampled at a rising edge:
  - Counter becomes 0.
  - FIFO becomes empty (count 0, pointers 0).
  - overflow becomes 0; out_valid becomes 0.
  - Reset has priority over any concurrent store or pop. Asserting reset mid-drain discards all queued words.
- After reset, the counter reads 0 in the first cycle with reset=0, then 1, 2, and so on.

## Test plan
- RAM round trip:
  - Store 0xDEADBEEF to 0x00000010, then load 0x00000010 → 0xDEADBEEF.
  - Load 0x00000010 + 4*MEM_WORDS → 0xDEADBEEF (aliasing).
  - Same-cycle read of 0x10 during the store → previous contents.
- Counter:
  - Release reset, then read CYCLE (0x80000000) on 3 consecutive cycles → 0, 1, 2.
  - Store 0xFFFFFFFE to CYCLE, then read over the next 3 cycles → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- FIFO order and handshake:
  - With out_ready=0, push 0x11, 0x22, 0x33 to 0x80000004.
  - STATUS → 0x0000000C (count 3).
  - out_valid=1 and out_data=0x11 held stable.
  - Assert out_ready → 0x11, 0x22, 0x33 on consecutive cycles, then out_valid=0 and STATUS=0x00000001.
- Overflow:
  - With out_ready=0, push 5 words into a depth-4 FIFO. The fifth is dropped; STATUS=0x00000112.
  - Store 0x100 to 0x80000008 → STATUS=0x00000012.
  - Drain → only the first 4 words appear.
- Full with simultaneous push/pop:
  - With the FIFO full and out_ready=1, push 0x55.
  - count stays 4, overflow stays 0, and 0x55 drains last.
- Reset mid-operation:
  - With 3 words queued and the counter at 100, pulse reset for 1 cycle while WE=1 to TXDATA.
  - out_valid=0, STATUS=0x00000001, CYCLE reads 0; RAM contents are unchanged.
